sdram_resp: RTL and testbench

Synthesizable single-chip SDR SDRAM responder: decodes the command bus driven by the team's SDRAM controllers (sdram2 and siblings), tracks per-bank open rows, and services ACTIVE/READ/WRITE/PRECHARGE/AUTO_REFRESH/LOAD_MODE with mode-register-programmed CAS latency and burst behaviour, backed by an internal word array. It sits on the device side of the controller's pins in simulation benches and loopback FPGA test builds, and it flags protocol violations.

---
 rtl/sdram_pkg.sv | 46 ++++
 rtl/sdram_resp_burst.sv | 84 ++++++++
 rtl/sdram_resp.sv | 214 +++++++++++++++++++++
 tb/tb_sdram_resp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the sdram_resp device model.
//   CMD_*         3-bit {nRAS,nCAS,nWE} command encodings
//   bank_state_t  per-bank {open, row} entry
//   err_code_e    protocol error codes reported on err_code
//   mode_cfg_t    decoded mode register fields
//   decode_mode   mode register -> mode_cfg_t
package sdram_pkg;

    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;

    typedef struct packed {
        logic        open;
        logic [12:0] row;
    } bank_state_t;

    typedef enum logic [2:0] {
        ErrNone       = 3'd0,
        ErrClosedBank = 3'd1,
        ErrActOpen    = 3'd2,
        ErrNoInit     = 3'd3,
        ErrRefOpen    = 3'd4
    } err_code_e;

    typedef struct packed {
        logic [1:0] bl_log2;    // burst length = 1 << bl_log2
        logic       interleave;
        logic       cl3;        // 1: CAS latency 3, 0: CAS latency 2
        logic       single_wr;
    } mode_cfg_t;

    function automatic mode_cfg_t decode_mode(input logic [12:0] mode);
        mode_cfg_t cfg;
        // Codes 4..7 are reserved and fall back to a single-word burst.
        cfg.bl_log2    = mode[2] ? 2'd0 : mode[1:0];
        cfg.interleave = mode[3];
        cfg.cl3        = (mode[6:4] == 3'd3);
        cfg.single_wr  = mode[9];
        return cfg;
    endfunction

endpackage

// File: rtl/sdram_resp_burst.sv
// sdram_resp_burst: burst column sequencer with CAS-latency delay for reads.
//   clk, rst_n  clock, async active-low reset
//   i_en        clock enable (cke); 0 freezes all state
//   i_start     accepted READ/WRITE this edge (truncates any running burst)
//   i_rd        1 = read burst, 0 = write burst
//   i_col       base column from the command
//   i_cfg       decoded mode (BL, CL, order, single-location writes)
//   o_col       column of the word serviced at the next edge
//   o_valid     a burst word is serviced at the next edge
//   o_rd        direction of the running burst
//   o_last      the serviced word is the final one of the burst
module sdram_resp_burst
    import sdram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_start,
    input  logic       i_rd,
    input  logic [7:0] i_col,
    input  mode_cfg_t  i_cfg,
    output logic [7:0] o_col,
    output logic       o_valid,
    output logic       o_rd,
    output logic       o_last
);

    logic       r_active;
    logic       r_rd;
    logic       r_dly;
    logic [2:0] r_k;
    logic [7:0] r_col;
    logic [1:0] r_bl_log2;
    logic       r_ilv;

    logic [2:0] w_mask;
    logic [2:0] w_low;
    logic       w_wr_cont;

    always_comb begin
        w_mask    = 3'((4'd1 << r_bl_log2) - 4'd1);
        w_low     = r_ilv ? (r_col[2:0] ^ r_k) : (r_col[2:0] + r_k);
        // Only the low log2(BL) column bits wrap; the rest stay at the base column.
        o_col     = {r_col[7:3], (r_col[2:0] & ~w_mask) | (w_low & w_mask)};
        o_valid   = r_active & ~r_dly;
        o_last    = o_valid & (r_k == w_mask);
        o_rd      = r_rd;
        w_wr_cont = (i_cfg.bl_log2 != 2'd0) & ~i_cfg.single_wr;
    end

    // Reads: word 0 is serviced CL-1 edges after the command, so CL3 needs one
    // extra wait edge. Writes: word 0 is taken at the command edge by the top,
    // so the sequencer starts at word 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_rd      <= 1'b0;
            r_dly     <= 1'b0;
            r_k       <= 3'd0;
            r_col     <= 8'd0;
            r_bl_log2 <= 2'd0;
            r_ilv     <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_active  <= i_rd | w_wr_cont;
                r_rd      <= i_rd;
                r_dly     <= i_rd & i_cfg.cl3;
                r_k       <= i_rd ? 3'd0 : 3'd1;
                r_col     <= i_col;
                r_bl_log2 <= i_cfg.bl_log2;
                r_ilv     <= i_cfg.interleave;
            end else if (r_active) begin
                if (r_dly) begin
                    r_dly <= 1'b0;
                end else if (o_last) begin
                    r_active <= 1'b0;
                end else begin
                    r_k <= r_k + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_resp.sv
// sdram_resp: single-chip SDR SDRAM device model driven by an SDRAM controller.
//   clk, rst_n                      clock, async active-low reset
//   sdram_cke                       clock enable; 0 freezes state, bus ignored
//   sdram_ncs/nras/ncas/nwe         command pins
//   sdram_ba, sdram_a               bank and multiplexed address
//   sdram_dqml, sdram_dqmh          write byte masks (1 = masked)
//   sdram_dq_i                      write data
//   sdram_dq_o, sdram_dq_oe         read data and its drive enable
//   mode_reg                        last LOAD_MODE value
//   init_ok                         legal init sequence completed
//   rfs_cnt                         saturating AUTO_REFRESH count
//   err_flag, err_code              sticky protocol error and first error code
module sdram_resp
    import sdram_pkg::*;
#(
    parameter int unsigned MEM_AW = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_cke,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] sdram_dq_i,
    output logic [15:0] sdram_dq_o,
    output logic        sdram_dq_oe,
    output logic [12:0] mode_reg,
    output logic        init_ok,
    output logic [15:0] rfs_cnt,
    output logic        err_flag,
    output logic [2:0]  err_code
);

    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    // Command decode
    logic [2:0]  w_cmd;
    logic        w_cmd_en, w_act, w_rd, w_wr, w_pre, w_ref, w_lmr;

    // Bank table and burst context
    bank_state_t r_bank [4];
    logic        w_bank_open, w_any_open;
    logic [12:0] w_bank_row;
    logic [1:0]  r_ba;
    logic [10:0] r_row;
    logic        r_ap;

    mode_cfg_t   w_cfg;
    logic        w_start, w_wr_cont, w_wr_ap_now, w_old_use, w_ap_close;
    logic [7:0]  w_seq_col;
    logic        w_seq_valid, w_seq_rd, w_seq_last;

    // Backing store
    logic [15:0]       r_mem [MEM_DEPTH];
    logic [20:0]       w_new_full, w_seq_full;
    logic [MEM_AW-1:0] w_new_idx, w_seq_idx, w_mem_idx;
    logic              w_mem_we;
    logic [1:0]        w_mem_be;

    // Status
    logic [15:0] r_dq_o;
    logic        r_dq_oe;
    logic [12:0] r_mode_reg;
    logic        r_init_ok, r_pre_all_seen;
    logic [1:0]  r_ref_seen;
    logic [15:0] r_rfs_cnt;
    logic        r_err_flag;
    err_code_e   r_err_code, w_err_now;
    logic        w_unused;

    always_comb begin
        w_cmd    = {sdram_nras, sdram_ncas, sdram_nwe};
        w_cmd_en = sdram_cke & ~sdram_ncs;
        w_act    = w_cmd_en & (w_cmd == CMD_ACTIVE);
        w_rd     = w_cmd_en & (w_cmd == CMD_READ);
        w_wr     = w_cmd_en & (w_cmd == CMD_WRITE);
        w_pre    = w_cmd_en & (w_cmd == CMD_PRECHARGE);
        w_ref    = w_cmd_en & (w_cmd == CMD_REFRESH);
        w_lmr    = w_cmd_en & (w_cmd == CMD_LOAD_MODE);

        w_bank_open = r_bank[sdram_ba].open;
        w_bank_row  = r_bank[sdram_ba].row;
        w_any_open  = r_bank[0].open | r_bank[1].open | r_bank[2].open | r_bank[3].open;

        w_cfg       = decode_mode(r_mode_reg);
        // READ/WRITE to a closed bank is rejected and leaves any running burst alone.
        w_start     = (w_rd | w_wr) & w_bank_open;
        w_wr_cont   = (w_cfg.bl_log2 != 2'd0) & ~w_cfg.single_wr;
        w_wr_ap_now = w_start & w_wr & sdram_a[10] & ~w_wr_cont;
        // A new command truncates the running burst; only a read-on-read still
        // lets the old burst deliver the word already due at this edge.
        w_old_use   = w_seq_valid & (~w_start | (w_seq_rd & w_rd));
        w_ap_close  = w_old_use & w_seq_last & r_ap;

        w_new_full = {sdram_ba, w_bank_row[10:0], sdram_a[7:0]};
        w_seq_full = {r_ba, r_row, w_seq_col};
        w_new_idx  = w_new_full[MEM_AW-1:0];
        w_seq_idx  = w_seq_full[MEM_AW-1:0];

        w_mem_we  = 1'b0;
        w_mem_idx = w_new_idx;
        w_mem_be  = ~{sdram_dqmh, sdram_dqml};
        if (w_start & w_wr) begin
            w_mem_we = 1'b1;
        end else if (w_old_use & ~w_seq_rd) begin
            w_mem_we  = 1'b1;
            w_mem_idx = w_seq_idx;
        end

        w_err_now = ErrNone;
        if ((w_rd | w_wr) & ~w_bank_open) begin
            w_err_now = ErrClosedBank;
        end else if (w_act & w_bank_open) begin
            w_err_now = ErrActOpen;
        end else if ((w_act | w_rd | w_wr) & ~r_init_ok) begin
            w_err_now = ErrNoInit;
        end else if (w_ref & w_any_open) begin
            w_err_now = ErrRefOpen;
        end

        // Row bits above 10 and address bits beyond MEM_AW alias silently.
        w_unused = ^{w_bank_row[12:11], w_new_full, w_seq_full};
    end

    sdram_resp_burst u_burst (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (sdram_cke),
        .i_start (w_start),
        .i_rd    (w_rd),
        .i_col   (sdram_a[7:0]),
        .i_cfg   (w_cfg),
        .o_col   (w_seq_col),
        .o_valid (w_seq_valid),
        .o_rd    (w_seq_rd),
        .o_last  (w_seq_last)
    );

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (sdram_cke && w_mem_we) begin
            if (w_mem_be[0]) r_mem[w_mem_idx][7:0]  <= sdram_dq_i[7:0];
            if (w_mem_be[1]) r_mem[w_mem_idx][15:8] <= sdram_dq_i[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_bank[i] <= '0;
            r_ba           <= 2'd0;
            r_row          <= 11'd0;
            r_ap           <= 1'b0;
            r_dq_o         <= 16'd0;
            r_dq_oe        <= 1'b0;
            r_mode_reg     <= 13'd0;
            r_init_ok      <= 1'b0;
            r_pre_all_seen <= 1'b0;
            r_ref_seen     <= 2'd0;
            r_rfs_cnt      <= 16'd0;
            r_err_flag     <= 1'b0;
            r_err_code     <= ErrNone;
        end else if (sdram_cke) begin
            // Later assignments win: an ACTIVE on the auto-precharge edge reopens.
            if (w_ap_close)  r_bank[r_ba].open     <= 1'b0;
            if (w_wr_ap_now) r_bank[sdram_ba].open <= 1'b0;
            if (w_pre) begin
                if (sdram_a[10]) begin
                    for (int i = 0; i < 4; i++) r_bank[i].open <= 1'b0;
                end else begin
                    r_bank[sdram_ba].open <= 1'b0;
                end
            end
            if (w_act) r_bank[sdram_ba] <= {1'b1, sdram_a};

            if (w_start) begin
                r_ba  <= sdram_ba;
                r_row <= w_bank_row[10:0];
                r_ap  <= sdram_a[10];
            end

            if (w_old_use & w_seq_rd) begin
                r_dq_o  <= r_mem[w_seq_idx];
                r_dq_oe <= 1'b1;
            end else begin
                r_dq_oe <= 1'b0;
            end

            if (w_lmr) r_mode_reg <= sdram_a;
            if (w_pre & sdram_a[10]) r_pre_all_seen <= 1'b1;
            if (w_ref && (r_ref_seen != 2'd2)) r_ref_seen <= r_ref_seen + 2'd1;
            if (w_lmr && r_pre_all_seen && (r_ref_seen == 2'd2)) r_init_ok <= 1'b1;
            if (w_ref && (r_rfs_cnt != 16'hFFFF)) r_rfs_cnt <= r_rfs_cnt + 16'd1;

            if (!r_err_flag && (w_err_now != ErrNone)) begin
                r_err_flag <= 1'b1;
                r_err_code <= w_err_now;
            end
        end
    end

    assign sdram_dq_o  = r_dq_o;
    assign sdram_dq_oe = r_dq_oe;
    assign mode_reg    = r_mode_reg;
    assign init_ok     = r_init_ok;
    assign rfs_cnt     = r_rfs_cnt;
    assign err_flag    = r_err_flag;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_sdram_resp.sv
// tb_sdram_resp: directed bench for sdram_resp with a read-data scoreboard.
module tb_sdram_resp;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_a;
    logic        sdram_dqml, sdram_dqmh;
    logic [15:0] sdram_dq_i;
    logic [15:0] sdram_dq_o;
    logic        sdram_dq_oe;
    logic [12:0] mode_reg;
    logic        init_ok;
    logic [15:0] rfs_cnt;
    logic        err_flag;
    logic [2:0]  err_code;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sdram_resp #(.MEM_AW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdram_cke   (sdram_cke),
        .sdram_ncs   (sdram_ncs),
        .sdram_nras  (sdram_nras),
        .sdram_ncas  (sdram_ncas),
        .sdram_nwe   (sdram_nwe),
        .sdram_ba    (sdram_ba),
        .sdram_a     (sdram_a),
        .sdram_dqml  (sdram_dqml),
        .sdram_dqmh  (sdram_dqmh),
        .sdram_dq_i  (sdram_dq_i),
        .sdram_dq_o  (sdram_dq_o),
        .sdram_dq_oe (sdram_dq_oe),
        .mode_reg    (mode_reg),
        .init_ok     (init_ok),
        .rfs_cnt     (rfs_cnt),
        .err_flag    (err_flag),
        .err_code    (err_code)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic bus_nop();
        sdram_ncs  = 1'b1;
        sdram_nras = 1'b1;
        sdram_ncas = 1'b1;
        sdram_nwe  = 1'b1;
        sdram_dqml = 1'b0;
        sdram_dqmh = 1'b0;
        sdram_dq_i = 16'h0000;
    endtask

    // Drive one command for one edge, then return the bus to NOP.
    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] dq, input logic dqmh);
        sdram_ncs  = 1'b0;
        {sdram_nras, sdram_ncas, sdram_nwe} = c;
        sdram_ba   = ba;
        sdram_a    = a;
        sdram_dq_i = dq;
        sdram_dqmh = dqmh;
        sdram_dqml = 1'b0;
        @(posedge clk);
        #1;
        bus_nop();
    endtask

    // Follow-on write burst word on a NOP cycle.
    task automatic wdata(input logic [15:0] dq);
        sdram_dq_i = dq;
        @(posedge clk);
        #1;
        bus_nop();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every driven read word is popped in order on the far edge.
    always @(negedge clk) begin
        if (rst_n && sdram_dq_oe) begin
            check("rd_word_pending", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) check("rd_word", sdram_dq_o, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sdram_cke = 1'b1;
        sdram_ba  = 2'd0;
        sdram_a   = 13'd0;
        bus_nop();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dq_oe", 16'(sdram_dq_oe), 16'd0);
        check("rst_dq_o", sdram_dq_o, 16'h0000);
        check("rst_mode", 16'(mode_reg), 16'h0000);
        check("rst_init_ok", 16'(init_ok), 16'd0);
        check("rst_rfs_cnt", rfs_cnt, 16'd0);
        check("rst_err_flag", 16'(err_flag), 16'd0);
        check("rst_err_code", 16'(err_code), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Init: PRECHARGE-all, 8 refreshes, LOAD_MODE 0x221 (BL2 seq CL2 single writes)
        cmd(C_PRE, 2'd0, 13'h0400, 16'h0, 1'b0);
        repeat (8) cmd(C_REF, 2'd0, 13'h0000, 16'h0, 1'b0);
        idle(2);
        check("rfs_cnt_8", rfs_cnt, 16'd8);
        check("init_before_lmr", 16'(init_ok), 16'd0);
        cmd(C_LMR, 2'd0, 13'h0221, 16'h0, 1'b0);
        idle(2);
        check("init_ok", 16'(init_ok), 16'd1);
        check("mode_reg_221", 16'(mode_reg), 16'h0221);
        check("err_after_init", 16'(err_flag), 16'd0);

        // Basic write/read with read-latency timing
        cmd(C_ACT, 2'd1, 13'h0012, 16'h0, 1'b0);
        cmd(C_WR, 2'd1, 13'h0010, 16'hA5A5, 1'b0);
        cmd(C_WR, 2'd1, 13'h0011, 16'h5A5A, 1'b0);
        exp_q.push_back(16'hA5A5);
        exp_q.push_back(16'h5A5A);
        cmd(C_RD, 2'd1, 13'h0010, 16'h0, 1'b0);
        check("rd_oe_at_n", 16'(sdram_dq_oe), 16'd0);
        idle(1);
        check("rd_oe_at_n1", 16'(sdram_dq_oe), 16'd1);
        check("rd_word0_at_n1", sdram_dq_o, 16'hA5A5);
        idle(1);
        check("rd_oe_at_n2", 16'(sdram_dq_oe), 16'd1);
        idle(1);
        check("rd_oe_at_n3", 16'(sdram_dq_oe), 16'd0);

        // Byte mask: upper byte masked keeps 0x12
        cmd(C_WR, 2'd1, 13'h0020, 16'h1234, 1'b0);
        cmd(C_WR, 2'd1, 13'h0021, 16'h0BEE, 1'b0);
        cmd(C_WR, 2'd1, 13'h0020, 16'hFFFF, 1'b1);
        exp_q.push_back(16'h12FF);
        exp_q.push_back(16'h0BEE);
        cmd(C_RD, 2'd1, 13'h0020, 16'h0, 1'b0);
        idle(4);

        // Burst write (BL2, a[9]=0): second word on the following edge
        cmd(C_LMR, 2'd0, 13'h0021, 16'h0, 1'b0);
        cmd(C_WR, 2'd1, 13'h0030, 16'h1111, 1'b0);
        wdata(16'h2222);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        cmd(C_RD, 2'd1, 13'h0030, 16'h0, 1'b0);
        idle(4);

        // BL4 ordering, sequential then interleaved
        cmd(C_LMR, 2'd0, 13'h0222, 16'h0, 1'b0);
        for (int c = 4; c < 8; c++) cmd(C_WR, 2'd1, 13'(c), 16'hC000 | 16'(c), 1'b0);
        exp_q.push_back(16'hC006); exp_q.push_back(16'hC007);
        exp_q.push_back(16'hC004); exp_q.push_back(16'hC005);
        cmd(C_RD, 2'd1, 13'h0006, 16'h0, 1'b0);
        idle(6);
        exp_q.push_back(16'hC005); exp_q.push_back(16'hC006);
        exp_q.push_back(16'hC007); exp_q.push_back(16'hC004);
        cmd(C_RD, 2'd1, 13'h0005, 16'h0, 1'b0);
        idle(6);
        cmd(C_LMR, 2'd0, 13'h022A, 16'h0, 1'b0);
        exp_q.push_back(16'hC006); exp_q.push_back(16'hC007);
        exp_q.push_back(16'hC004); exp_q.push_back(16'hC005);
        cmd(C_RD, 2'd1, 13'h0006, 16'h0, 1'b0);
        idle(6);
        exp_q.push_back(16'hC005); exp_q.push_back(16'hC004);
        exp_q.push_back(16'hC007); exp_q.push_back(16'hC006);
        cmd(C_RD, 2'd1, 13'h0005, 16'h0, 1'b0);
        idle(6);
        check("err_before_closed", 16'(err_flag), 16'd0);

        // Errors: READ to closed bank, then REFRESH with a bank open
        cmd(C_RD, 2'd2, 13'h0000, 16'h0, 1'b0);
        check("closed_rd_oe_n", 16'(sdram_dq_oe), 16'd0);
        idle(1);
        check("closed_rd_oe_n1", 16'(sdram_dq_oe), 16'd0);
        idle(2);
        check("closed_err_flag", 16'(err_flag), 16'd1);
        check("closed_err_code", 16'(err_code), 16'd1);
        cmd(C_REF, 2'd0, 13'h0000, 16'h0, 1'b0);
        idle(2);
        check("first_err_held", 16'(err_code), 16'd1);
        check("err_flag_sticky", 16'(err_flag), 16'd1);
        check("rfs_cnt_9", rfs_cnt, 16'd9);
        check("sb_drained", 16'(exp_q.size()), 16'd0);

        // CL3 read, reset right after the first word appears
        cmd(C_LMR, 2'd0, 13'h0232, 16'h0, 1'b0);
        cmd(C_RD, 2'd1, 13'h0004, 16'h0, 1'b0);
        check("cl3_oe_n", 16'(sdram_dq_oe), 16'd0);
        idle(1);
        check("cl3_oe_n1", 16'(sdram_dq_oe), 16'd0);
        idle(1);
        check("cl3_oe_n2", 16'(sdram_dq_oe), 16'd1);
        check("cl3_word0", sdram_dq_o, 16'hC004);
        rst_n = 1'b0;
        #1;
        check("rst_mid_oe", 16'(sdram_dq_oe), 16'd0);
        check("rst_mid_init", 16'(init_ok), 16'd0);
        check("rst_mid_mode", 16'(mode_reg), 16'h0000);
        check("rst_mid_err", 16'(err_flag), 16'd0);
        check("rst_mid_rfs", rfs_cnt, 16'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // A refresh now raises no error only if every bank was closed by reset.
        cmd(C_REF, 2'd0, 13'h0000, 16'h0, 1'b0);
        idle(2);
        check("banks_closed", 16'(err_flag), 16'd0);
        check("rfs_after_rst", rfs_cnt, 16'd1);
        cmd(C_ACT, 2'd0, 13'h0001, 16'h0, 1'b0);
        idle(2);
        check("act_no_init_code", 16'(err_code), 16'd3);
        check("oe_quiet_end", 16'(sdram_dq_oe), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
